// File: rtl/hus_pkg.sv
// Shared types, defaults and saturation helpers for the HUS mixer output stage.
package hus_pkg;

    localparam int SMP_W_DEF    = 16;
    localparam int VOL_W_DEF    = 6;
    localparam int ACC_W_DEF    = 28;
    localparam int SHIFT_DEF    = 6;
    localparam int BCLK_DIV_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RIGHT = 2'd2,
        ST_LATCH = 2'd3
    } mix_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic sat16_hit(input logic signed [31:0] v);
        return (v > 32'sd32767) || (v < -32'sd32768);
    endfunction

endpackage

// File: rtl/hus_mixout_if.sv
// Channel handshake from the HUS mixer MATH phase into hus_mixout.
interface hus_mixout_if #(
    parameter int SMP_W = hus_pkg::SMP_W_DEF,
    parameter int VOL_W = hus_pkg::VOL_W_DEF
);
    logic                    in_vld;
    logic                    in_rdy;
    logic                    in_last;
    logic signed [SMP_W-1:0] in_smp;
    logic [VOL_W-1:0]        in_vol_l;
    logic [VOL_W-1:0]        in_vol_r;

    modport master (output in_vld, output in_last, output in_smp,
                    output in_vol_l, output in_vol_r, input in_rdy);
    modport slave  (input in_vld, input in_last, input in_smp,
                    input in_vol_l, input in_vol_r, output in_rdy);
endinterface

// File: rtl/hus_dac_ser.sv
// Stereo DAC serializer: on each audio strobe shifts {left,right} out MSB first, 32 bclk periods.
module hus_dac_ser #(
    parameter int BCLK_DIV = hus_pkg::BCLK_DIV_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        au_stb,
    input  logic [15:0] load_l,
    input  logic [15:0] load_r,
    output logic        dac_bclk,
    output logic        dac_lrck,
    output logic        dac_sdata
);
    localparam int BSH   = $clog2(BCLK_DIV);
    // 32 bits x 2 half-periods x BCLK_DIV clocks; the top 5 bits are the bit index
    localparam int CNT_W = BSH + 6;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic [31:0]      shr_q, shr_d;
    logic [4:0]       bit_idx;

    always_comb begin
        cnt_d = cnt_q;
        act_d = act_q;
        shr_d = shr_q;
        if (au_stb) begin
            cnt_d = '0;
            act_d = 1'b1;
            shr_d = {load_l, load_r};
        end else if (act_q) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q)
                act_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            act_q <= 1'b0;
            shr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            shr_q <= shr_d;
        end
    end

    assign bit_idx   = cnt_q[CNT_W-1 -: 5];
    assign dac_bclk  = act_q & cnt_q[BSH];
    assign dac_lrck  = ~act_q | ~bit_idx[4];
    assign dac_sdata = act_q & shr_q[5'd31 - bit_idx];

endmodule

// File: rtl/hus_mixout.sv
// HUS mixer output stage: accumulates L/R over a frame, saturates, latches and serializes to the DAC.
// Optional sticky clip flag enabled by defining HUS_MIXOUT_CLIP_EN.
module hus_mixout
    import hus_pkg::*;
#(
    parameter int SMP_W    = SMP_W_DEF,
    parameter int VOL_W    = VOL_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int SHIFT    = SHIFT_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         au_stb,
    input  logic         frame_start,
    hus_mixout_if.slave  in_if,
    output logic         frame_done,
    output logic         dac_bclk,
    output logic         dac_lrck,
    output logic         dac_sdata,
    output logic         clip
);
    localparam int PROD_W = SMP_W + VOL_W + 1;

    mix_state_e              state_q, state_d;
    logic                    in_rdy_q, in_rdy_d;
    logic                    frame_done_q, frame_done_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [SMP_W-1:0] smp_q, smp_d;
    logic [VOL_W-1:0]        vol_r_q, vol_r_d;
    logic                    last_q, last_d;
    logic signed [15:0]      out_l_q, out_l_d, out_r_q, out_r_d;

    logic signed [SMP_W-1:0]  mul_smp;
    logic [VOL_W-1:0]         mul_vol;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sh_l, sh_r;
    logic signed [31:0]       wide_l, wide_r;
    logic                     accept;

    // One multiplier: left product in ST_RUN from the bus, right product in ST_RIGHT from the capture
    always_comb begin
        if (state_q == ST_RUN) begin
            mul_smp = in_if.in_smp;
            mul_vol = in_if.in_vol_l;
        end else begin
            mul_smp = smp_q;
            mul_vol = vol_r_q;
        end
        prod     = mul_smp * $signed({1'b0, mul_vol});
        prod_ext = ACC_W'(prod);
        sh_l     = acc_l_q >>> SHIFT;
        sh_r     = acc_r_q >>> SHIFT;
        wide_l   = 32'(sh_l);
        wide_r   = 32'(sh_r);
    end

    assign accept = (state_q == ST_RUN) && in_rdy_q && in_if.in_vld;

`ifdef HUS_MIXOUT_CLIP_EN
    logic clip_q, clip_d;
`endif

    always_comb begin
        state_d      = state_q;
        in_rdy_d     = in_rdy_q;
        frame_done_d = 1'b0;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        smp_d        = smp_q;
        vol_r_d      = vol_r_q;
        last_d       = last_q;
        out_l_d      = out_l_q;
        out_r_d      = out_r_q;
`ifdef HUS_MIXOUT_CLIP_EN
        clip_d       = clip_q;
`endif
        case (state_q)
            ST_IDLE: in_rdy_d = 1'b0;
            ST_RUN: begin
                if (accept) begin
                    acc_l_d  = acc_l_q + prod_ext;
                    smp_d    = in_if.in_smp;
                    vol_r_d  = in_if.in_vol_r;
                    last_d   = in_if.in_last;
                    state_d  = ST_RIGHT;
                    in_rdy_d = 1'b0;
                end
            end
            ST_RIGHT: begin
                acc_r_d  = acc_r_q + prod_ext;
                state_d  = last_q ? ST_LATCH : ST_RUN;
                in_rdy_d = ~last_q;
            end
            ST_LATCH: begin
                out_l_d      = sat16(wide_l);
                out_r_d      = sat16(wide_r);
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
                in_rdy_d     = 1'b0;
`ifdef HUS_MIXOUT_CLIP_EN
                clip_d = clip_q | sat16_hit(wide_l) | sat16_hit(wide_r);
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                in_rdy_d = 1'b0;
            end
        endcase
        // A new frame wins over everything, including a pending latch
        if (frame_start) begin
            acc_l_d      = '0;
            acc_r_d      = '0;
            state_d      = ST_RUN;
            in_rdy_d     = 1'b1;
            frame_done_d = 1'b0;
            out_l_d      = out_l_q;
            out_r_d      = out_r_q;
`ifdef HUS_MIXOUT_CLIP_EN
            clip_d       = clip_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_rdy_q     <= 1'b0;
            frame_done_q <= 1'b0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            smp_q        <= '0;
            vol_r_q      <= '0;
            last_q       <= 1'b0;
            out_l_q      <= '0;
            out_r_q      <= '0;
        end else begin
            state_q      <= state_d;
            in_rdy_q     <= in_rdy_d;
            frame_done_q <= frame_done_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            smp_q        <= smp_d;
            vol_r_q      <= vol_r_d;
            last_q       <= last_d;
            out_l_q      <= out_l_d;
            out_r_q      <= out_r_d;
        end
    end

`ifdef HUS_MIXOUT_CLIP_EN
    always_ff @(posedge clk) begin
        if (reset) clip_q <= 1'b0;
        else       clip_q <= clip_d;
    end
    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

    assign in_if.in_rdy = in_rdy_q;
    assign frame_done   = frame_done_q;

    hus_dac_ser #(.BCLK_DIV(BCLK_DIV)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .au_stb    (au_stb),
        .load_l    (out_l_q),
        .load_r    (out_r_q),
        .dac_bclk  (dac_bclk),
        .dac_lrck  (dac_lrck),
        .dac_sdata (dac_sdata)
    );

endmodule

// File: tb/tb_hus_mixout.sv
// Scoreboard bench for hus_mixout: frames are scored by deserializing the DAC stream.
module tb_hus_mixout;

    logic clk = 1'b0;
    logic reset, au_stb, frame_start;
    logic frame_done, dac_bclk, dac_lrck, dac_sdata, clip;

    hus_mixout_if #(.SMP_W(16), .VOL_W(6)) bus ();

    hus_mixout dut (
        .clk         (clk),
        .reset       (reset),
        .au_stb      (au_stb),
        .frame_start (frame_start),
        .in_if       (bus),
        .frame_done  (frame_done),
        .dac_bclk    (dac_bclk),
        .dac_lrck    (dac_lrck),
        .dac_sdata   (dac_sdata),
        .clip        (clip)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
    pair_t exp_q[$];

    int chk_cnt = 0;
    int pass_cnt = 0;

    int q_smp[$];
    int q_vl[$];
    int q_vr[$];
    logic [15:0] mdl_l = 16'h0;
    logic [15:0] mdl_r = 16'h0;
    bit          mdl_clip = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] sat_side(input longint sum, inout bit clipped);
        longint s;
        s = sum >>> 6;
        if (s > 32767)       begin clipped = 1'b1; return 16'h7FFF; end
        else if (s < -32768) begin clipped = 1'b1; return 16'h8000; end
        return s[15:0];
    endfunction

    // Reference: sum of smp*vol over the queued channels, shift, clamp
    task automatic model_frame();
        longint sl = 0;
        longint sr = 0;
        bit c = 1'b0;
        foreach (q_smp[i]) begin
            sl += longint'(q_smp[i]) * q_vl[i];
            sr += longint'(q_smp[i]) * q_vr[i];
        end
        mdl_l = sat_side(sl, c);
        mdl_r = sat_side(sr, c);
        if (c) mdl_clip = 1'b1;
    endtask

    task automatic add_ch(input int smp, input int vl, input int vr);
        q_smp.push_back(smp); q_vl.push_back(vl); q_vr.push_back(vr);
    endtask

    task automatic add_rand(input int n);
        logic signed [15:0] s;
        for (int i = 0; i < n; i++) begin
            s = 16'($urandom);
            add_ch(int'(s), $urandom_range(0, 63), $urandom_range(0, 63));
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_ch(input int smp, input int vl, input int vr, input bit last);
        bit was;
        bit done = 1'b0;
        int sv;
        sv = smp;
        bus.in_vld = 1'b1; bus.in_smp = sv[15:0];
        bus.in_vol_l = 6'(vl); bus.in_vol_r = 6'(vr); bus.in_last = last;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk); was = bus.in_rdy;
            @(posedge clk); #1;
            if (was) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        bus.in_vld = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic play_frame();
        pulse_fs();
        foreach (q_smp[i]) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_ch(q_smp[i], q_vl[i], q_vr[i], i == q_smp.size() - 1);
        end
        wait_done();
        model_frame();
        q_smp.delete(); q_vl.delete(); q_vr.delete();
    endtask

    task automatic strobe(input bit push);
        pair_t p;
        p.l = mdl_l; p.r = mdl_r;
        if (push) exp_q.push_back(p);
        au_stb = 1'b1;
        @(posedge clk); #1;
        au_stb = 1'b0;
        repeat (64 * 8 + 4) @(posedge clk);
        @(negedge clk);
        chk("idle_bclk", dac_bclk, 0);
        chk("idle_lrck", dac_lrck, 1);
        chk("idle_sdata", dac_sdata, 0);
        @(posedge clk); #1;
    endtask

    // Monitor: collect 32 bits on bclk rising edges, score against the expected queue
    logic [31:0] mon_w, mon_lr;
    int          mon_nb = 0;
    logic        mon_pb = 1'b0;
    pair_t       mon_p;
    initial begin
        forever begin
            @(negedge clk);
            if (reset || au_stb) begin
                mon_nb = 0;
            end else if (dac_bclk && !mon_pb) begin
                mon_w  = {mon_w[30:0], dac_sdata};
                mon_lr = {mon_lr[30:0], dac_lrck};
                mon_nb++;
                if (mon_nb == 32) begin
                    mon_nb = 0;
                    if (exp_q.size() == 0) begin
                        chk("ser_unexpected", 1, 0);
                    end else begin
                        mon_p = exp_q.pop_front();
                        chk("ser_word", mon_w, {mon_p.l, mon_p.r});
                        chk("ser_lrck", mon_lr, 32'hFFFF_0000);
                    end
                end
            end
            mon_pb = dac_bclk;
        end
    end

    int acc_n;
    bit was_rdy;

    initial begin
        reset = 1'b1; au_stb = 1'b0; frame_start = 1'b0;
        bus.in_vld = 1'b0; bus.in_last = 1'b0; bus.in_smp = '0;
        bus.in_vol_l = '0; bus.in_vol_r = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", bus.in_rdy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bclk", dac_bclk, 0);
        chk("rst_lrck", dac_lrck, 1);
        chk("rst_sdata", dac_sdata, 0);
        chk("rst_clip", clip, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single channel, left only
        add_ch(16'h4000, 63, 0);
        play_frame();
        chk("single_mdl", {mdl_l, mdl_r}, 32'h3F00_0000);
        strobe(1'b1);

        // in_rdy cadence with in_vld held high for four channels
        add_rand(4);
        pulse_fs();
        acc_n = 0;
        bus.in_vld = 1'b1; bus.in_smp = q_smp[0][15:0];
        bus.in_vol_l = 6'(q_vl[0]); bus.in_vol_r = 6'(q_vr[0]); bus.in_last = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rdy_pattern", bus.in_rdy, (c % 2 == 0) ? 1 : 0);
            chk("fd_early", frame_done, 0);
            was_rdy = bus.in_rdy;
            @(posedge clk); #1;
            if (was_rdy) begin
                acc_n++;
                if (acc_n == 4) begin
                    bus.in_vld = 1'b0; bus.in_last = 1'b0;
                end else begin
                    bus.in_smp = q_smp[acc_n][15:0];
                    bus.in_vol_l = 6'(q_vl[acc_n]); bus.in_vol_r = 6'(q_vr[acc_n]);
                    bus.in_last = (acc_n == 3);
                end
            end
        end
        @(negedge clk); chk("fd_c8", frame_done, 0);
        @(negedge clk); chk("fd_c9", frame_done, 1);
        @(negedge clk); chk("fd_c10", frame_done, 0);
        @(posedge clk); #1;
        model_frame();
        q_smp.delete(); q_vl.delete(); q_vr.delete();
        strobe(1'b1);

        // Positive and negative saturation
        for (int i = 0; i < 32; i++) add_ch(32767, 63, 63);
        play_frame();
        chk("pos_sat_mdl", {mdl_l, mdl_r}, 32'h7FFF_7FFF);
        strobe(1'b1);
        for (int i = 0; i < 32; i++) add_ch(-32768, 63, 63);
        play_frame();
        chk("neg_sat_mdl", {mdl_l, mdl_r}, 32'h8000_8000);
        strobe(1'b1);

        // Partial frame discarded by a new frame_start
        add_rand(5);
        pulse_fs();
        for (int i = 0; i < 3; i++) send_ch(q_smp[i], q_vl[i], q_vr[i], 1'b0);
        @(posedge clk); #1;
        q_smp.delete(); q_vl.delete(); q_vr.delete();
        add_ch(16'h0100, 63, 63);
        play_frame();
        chk("partial_mdl", {mdl_l, mdl_r}, 32'h00FC_00FC);
        strobe(1'b1);
        // No new frame: the same pair repeats
        strobe(1'b1);

        for (int f = 0; f < 10; f++) begin
            add_rand($urandom_range(1, 64));
            play_frame();
            strobe(1'b1);
        end

`ifdef HUS_MIXOUT_CLIP_EN
        chk("clip_sticky", clip, mdl_clip);
`else
        chk("clip_tied", clip, 0);
`endif

        // Reset during serial bit 10
        au_stb = 1'b1;
        @(posedge clk); #1;
        au_stb = 1'b0;
        repeat (160) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_bclk", dac_bclk, 0);
        chk("mid_rst_lrck", dac_lrck, 1);
        chk("mid_rst_sdata", dac_sdata, 0);
        chk("mid_rst_clip", clip, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_l = 16'h0; mdl_r = 16'h0; mdl_clip = 1'b0;
        @(posedge clk); #1;
        strobe(1'b1);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
